alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 (processor core) and port 1 (game-logic coprocessor). Arbitrates with round-robin and drives the ALU operation/operand inputs from registered copies. Holds each operation for an opcode-dependent number of settle cycles, then registers result and error_flag and returns them to the winning requester over a valid/ready response handshake. Sits between both requesters and the ALU instance in the processor datapath.

Parameters:
MUL_CYCLES, 3, settle cycles for opcode 4'b0010 (MUL); minimum 1
DIV_CYCLES, 8, settle cycles for opcode 4'b0110 (DIV); minimum 1
BASE_CYCLES, 1, settle cycles for every other opcode; minimum 1

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  2  per-port request valid, bit i = port i
req_ready  output  2  per-port request accepted; one-hot or zero
req_operation_0 / req_operation_1  input  4  ALU opcode per port
req_operand_a_0 / req_operand_a_1  input  32  operand A per port
req_operand_b_0 / req_operand_b_1  input  32  operand B per port
alu_operation  output  4  to ALU operation
alu_operand_a  output  32  to ALU operand_a
alu_operand_b  output  32  to ALU operand_b
alu_result  input  32  from ALU result
alu_error_flag  input  2  from ALU error_flag
rsp_valid  output  2  per-port response valid; one-hot or zero
rsp_ready  input  2  per-port response consumed
rsp_result  output  32  registered result, shared by both ports
rsp_error_flag  output  2  registered error_flag, shared by both ports
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_error_flag=0, alu_* outputs=0, busy=0, last_grant=1 (so port 0 wins first), counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is set, grant port g. If both are set, g = port other than last_grant; otherwise g = the single requester. Assert req_ready[g] combinationally in the same cycle. On that edge, latch opcode and operands into the alu_* registers. Load counter with cycles(opcode)-1; set last_grant=g. Next state EXEC.
- req_ready is asserted only in IDLE. A requester must hold its valid and payload stable until it sees ready.
- EXEC: alu_* outputs stay stable. Counter decrements each cycle. When counter==0, capture alu_result and alu_error_flag into rsp_* and set rsp_valid[g]=1. Next state RESP.
- Latency from grant edge to rsp_valid: exactly cycles(opcode) clocks (ADD = 1, DIV = DIV_CYCLES).
- RESP: rsp_valid[g] and rsp_* stay stable until rsp_ready[g]=1. On that edge, clear rsp_valid and return to IDLE. A new grant happens no earlier than the next cycle. rsp_ready of the non-granted port is ignored.
- Back-to-back throughput: one operation per cycles(opcode)+2 clocks when rsp_ready is held high.
- Undefined or unsupported opcodes use BASE_CYCLES. Whatever the ALU returns, including a nonzero error_flag, is passed through unmodified. The arbiter never drops or retries a request.
- Divide-by-zero: the error_flag from the ALU is forwarded. The result value is whatever the ALU produces.
- Starvation bound: while both ports hold valid, grants alternate strictly 0,1,0,1.
- Reset mid-operation: the in-flight operation is discarded with no response. Arbitration restarts with port 0 priority.
- Only the registered alu_* values reach the ALU. A requester payload change after its grant has no effect.

Optional Feature:
ALU_ARB_STATS_EN
- Defined: adds three outputs: stat_grants_0 [15:0], stat_grants_1 [15:0] and stat_errors [15:0].
  - stat_grants_0/1 increment on each grant edge for their port.
  - stat_errors increments on each capture where alu_error_flag != 0.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Port 0 ADD 10+5, rsp_ready held 1 -> req_ready[0] in the IDLE cycle; rsp_valid[0] 1 clock later; rsp_result=15, rsp_error_flag=0; busy falls after the handshake.
- Port 1 DIV 40/4 with DIV_CYCLES=8 -> rsp_valid[1] exactly 8 clocks after the grant edge; rsp_result=10; alu_* outputs stable throughout EXEC.
- Port 0 DIV 10/0 -> rsp_error_flag equals the ALU's nonzero divide-by-zero flag; response delivered normally; with ALU_ARB_STATS_EN defined, stat_errors=1.
- Both ports continuously valid from reset (port 0 SUB 20-8, port 1 MUL 15*5) -> grants in order 0,1,0,1; results 12 and 75 on the matching rsp_valid bit; no grant while in RESP.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid and rsp_result stay stable; no new req_ready until one cycle after rsp_ready rises.
- reset_n pulsed low during EXEC of a DIV -> all outputs go to 0 immediately; no rsp_valid for the aborted operation; the next request with both ports valid is granted to port 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: two request ports plus the shared response channel.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_operation_0;
    logic [3:0]  req_operation_1;
    logic [31:0] req_operand_a_0;
    logic [31:0] req_operand_a_1;
    logic [31:0] req_operand_b_0;
    logic [31:0] req_operand_b_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error_flag;

    modport master (
        output req_valid, req_operation_0, req_operation_1,
               req_operand_a_0, req_operand_a_1, req_operand_b_0, req_operand_b_1,
               rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_error_flag
    );

    modport slave (
        input  req_valid, req_operation_0, req_operation_1,
               req_operand_a_0, req_operand_a_1, req_operand_b_0, req_operand_b_1,
               rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_error_flag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters with opcode-dependent settle time.
// Optional build macro ALU_ARB_STATS_EN adds saturating grant and error counters.
module alu_arbiter #(
    parameter int MUL_CYCLES  = 3,
    parameter int DIV_CYCLES  = 8,
    parameter int BASE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_arbiter_if.slave bus,
    output logic [3:0]  alu_operation,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error_flag,
    output logic        busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grants_0,
    output logic [15:0] stat_grants_1,
    output logic [15:0] stat_errors
`endif
);

    localparam logic [3:0]  OP_MUL  = 4'b0010;
    localparam logic [3:0]  OP_DIV  = 4'b0110;
    localparam logic [15:0] MUL_M1  = 16'(MUL_CYCLES - 1);
    localparam logic [15:0] DIV_M1  = 16'(DIV_CYCLES - 1);
    localparam logic [15:0] BASE_M1 = 16'(BASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  ready_next;
    logic        last_grant_reg;
    logic        grant_reg;
    logic [15:0] counter_reg;
    logic [3:0]  alu_operation_reg;
    logic [31:0] alu_operand_a_reg;
    logic [31:0] alu_operand_b_reg;
    logic [1:0]  rsp_valid_reg;
    logic [31:0] rsp_result_reg;
    logic [1:0]  rsp_error_flag_reg;

    logic        grant_sel;
    logic [3:0]  sel_operation;
    logic [31:0] sel_operand_a;
    logic [31:0] sel_operand_b;
    logic        do_grant;
    logic        do_capture;

    function automatic logic [15:0] settle_m1(input logic [3:0] op);
        case (op)
            OP_MUL:  return MUL_M1;
            OP_DIV:  return DIV_M1;
            default: return BASE_M1;
        endcase
    endfunction

    // With both ports pending, the port that did not win last time goes next.
    assign grant_sel     = (&bus.req_valid) ? ~last_grant_reg : bus.req_valid[1];
    assign sel_operation = grant_sel ? bus.req_operation_1 : bus.req_operation_0;
    assign sel_operand_a = grant_sel ? bus.req_operand_a_1 : bus.req_operand_a_0;
    assign sel_operand_b = grant_sel ? bus.req_operand_b_1 : bus.req_operand_b_0;
    assign do_grant      = (state_reg == IDLE) && (|bus.req_valid);
    assign do_capture    = (state_reg == EXEC) && (counter_reg == 16'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_next = 2'b00;
        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_next = EXEC;
                    ready_next = grant_sel ? 2'b10 : 2'b01;
                end
            end
            EXEC: begin
                if (counter_reg == 16'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[grant_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted even if a requester is already pending.
    assign bus.req_ready = reset_n ? ready_next : 2'b00;
    assign busy          = (state_reg != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg     <= 1'b1;
            grant_reg          <= 1'b0;
            counter_reg        <= 16'd0;
            alu_operation_reg  <= 4'd0;
            alu_operand_a_reg  <= 32'd0;
            alu_operand_b_reg  <= 32'd0;
            rsp_valid_reg      <= 2'b00;
            rsp_result_reg     <= 32'd0;
            rsp_error_flag_reg <= 2'b00;
        end else begin
            if (do_grant) begin
                alu_operation_reg <= sel_operation;
                alu_operand_a_reg <= sel_operand_a;
                alu_operand_b_reg <= sel_operand_b;
                counter_reg       <= settle_m1(sel_operation);
                last_grant_reg    <= grant_sel;
                grant_reg         <= grant_sel;
            end else if ((state_reg == EXEC) && (counter_reg != 16'd0)) begin
                counter_reg <= counter_reg - 16'd1;
            end

            if (do_capture) begin
                rsp_result_reg     <= alu_result;
                rsp_error_flag_reg <= alu_error_flag;
                rsp_valid_reg      <= grant_reg ? 2'b10 : 2'b01;
            end else if ((state_reg == RESP) && bus.rsp_ready[grant_reg]) begin
                rsp_valid_reg <= 2'b00;
            end
        end
    end

    assign alu_operation      = alu_operation_reg;
    assign alu_operand_a      = alu_operand_a_reg;
    assign alu_operand_b      = alu_operand_b_reg;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_result     = rsp_result_reg;
    assign bus.rsp_error_flag = rsp_error_flag_reg;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant_reg [2];
    logic [15:0] stat_error_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat_grant
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                stat_grant_reg[gi] <= 16'd0;
            end else if (do_grant && (grant_sel == 1'(gi)) && (stat_grant_reg[gi] != 16'hFFFF)) begin
                stat_grant_reg[gi] <= stat_grant_reg[gi] + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_error_reg <= 16'd0;
        end else if (do_capture && (alu_error_flag != 2'b00) && (stat_error_reg != 16'hFFFF)) begin
            stat_error_reg <= stat_error_reg + 16'd1;
        end
    end

    assign stat_grants_0 = stat_grant_reg[0];
    assign stat_grants_1 = stat_grant_reg[1];
    assign stat_errors   = stat_error_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; a stand-in ALU and a reference model live here.
module tb_alu_arbiter;

    localparam int MUL_C  = 3;
    localparam int DIV_C  = 8;
    localparam int BASE_C = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_arbiter_if bus();

    logic [3:0]  alu_operation;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [31:0] alu_result;
    logic [1:0]  alu_error_flag;
    logic        busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grants_0;
    logic [15:0] stat_grants_1;
    logic [15:0] stat_errors;
`endif

    alu_arbiter #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .BASE_CYCLES(BASE_C)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .alu_operation  (alu_operation),
        .alu_operand_a  (alu_operand_a),
        .alu_operand_b  (alu_operand_b),
        .alu_result     (alu_result),
        .alu_error_flag (alu_error_flag),
        .busy           (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grants_0  (stat_grants_0),
        .stat_grants_1  (stat_grants_1),
        .stat_errors    (stat_errors)
`endif
    );

    // Reference ALU: {error_flag, result}. Divide by zero flags 2'b01, unknown opcodes flag 2'b11.
    function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return {2'b00, a + b};
            4'd1: return {2'b00, a - b};
            4'd2: return {2'b00, a * b};
            4'd3: return {2'b00, a & b};
            4'd4: return {2'b00, a | b};
            4'd5: return {2'b00, a ^ b};
            4'd6: return (b == 32'd0) ? {2'b01, 32'hFFFF_FFFF} : {2'b00, a / b};
            default: return {2'b11, 32'd0};
        endcase
    endfunction

    function automatic int cycles(input logic [3:0] op);
        if (op == 4'd2) return MUL_C;
        if (op == 4'd6) return DIV_C;
        return BASE_C;
    endfunction

    assign {alu_error_flag, alu_result} = ref_alu(alu_operation, alu_operand_a, alu_operand_b);

    logic        drv_valid [2];
    logic [3:0]  drv_op [2];
    logic [31:0] drv_a [2];
    logic [31:0] drv_b [2];
    logic [1:0]  rr = 2'b11;
    int          rr_mode = 0;

    assign bus.req_valid       = {drv_valid[1], drv_valid[0]};
    assign bus.req_operation_0 = drv_op[0];
    assign bus.req_operation_1 = drv_op[1];
    assign bus.req_operand_a_0 = drv_a[0];
    assign bus.req_operand_a_1 = drv_a[1];
    assign bus.req_operand_b_0 = drv_b[0];
    assign bus.req_operand_b_1 = drv_b[1];
    assign bus.rsp_ready       = rr;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_grants [2];
    int model_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("[TB] ok %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Present a request, wait for its grant, push the expected response, then scramble the payload.
    task automatic drive(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [33:0] r;
        bit          granted;
        granted   = 1'b0;
        drv_op[p] = op;
        drv_a[p]  = a;
        drv_b[p]  = b;
        drv_valid[p] = 1'b1;
        r = ref_alu(op, a, b);
        e.res = r[31:0];
        e.err = r[33:32];
        for (int i = 0; i < 400 && !granted; i++) begin
            @(negedge clock);
            if (bus.req_ready[p]) granted = 1'b1;
        end
        if (!granted) begin
            check("grant_timeout", 64'd0, 64'd1);
        end else begin
            if (p == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            model_grants[p]++;
        end
        @(posedge clock);
        #2;
        drv_valid[p] = 1'b0;
        drv_op[p] = 4'($urandom);
        drv_a[p]  = $urandom;
        drv_b[p]  = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clock);
            if (!busy && bus.rsp_valid == 2'b00 && exp_q0.size() == 0 && exp_q1.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
        @(posedge clock);
        #2;
    endtask

    always begin
        @(posedge clock);
        #2;
        case (rr_mode)
            0:       rr = 2'b11;
            1:       rr = 2'($urandom);
            default: rr = 2'b00;
        endcase
    end

    // Monitor: grant order, EXEC stability, latency, response hold and scoreboard comparison.
    initial begin : monitor
        logic        last_g;
        logic        exp_g;
        logic        cur_port;
        logic        inflight;
        int          cur_edge;
        logic [3:0]  cur_op;
        logic [31:0] cur_a;
        logic [31:0] cur_b;
        logic        prev_hold;
        logic        prev_hs;
        logic [1:0]  prev_rv;
        logic [31:0] prev_res;
        logic [1:0]  prev_err;
        exp_t        e;
        logic        p;
        last_g = 1'b1; inflight = 1'b0; prev_hold = 1'b0; prev_hs = 1'b0; prev_rv = 2'b00;
        cur_port = 1'b0; cur_edge = 0; cur_op = 4'd0; cur_a = 32'd0; cur_b = 32'd0;
        prev_res = 32'd0; prev_err = 2'b00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                last_g = 1'b1; inflight = 1'b0; prev_hold = 1'b0; prev_hs = 1'b0; prev_rv = 2'b00;
                exp_q0.delete(); exp_q1.delete();
                model_grants[0] = 0; model_grants[1] = 0; model_errors = 0;
                continue;
            end
            if (prev_hs) check("busy_after_rsp", 64'(busy), 64'd0);
            prev_hs = 1'b0;

            if (bus.req_ready != 2'b00) begin
                exp_g = (bus.req_valid == 2'b11) ? ~last_g : bus.req_valid[1];
                check("grant_port", 64'(bus.req_ready), exp_g ? 64'd2 : 64'd1);
                check("grant_while_busy", 64'(busy), 64'd0);
                last_g   = exp_g;
                cur_port = bus.req_ready[1];
                cur_edge = cyc + 1;
                cur_op   = cur_port ? bus.req_operation_1 : bus.req_operation_0;
                cur_a    = cur_port ? bus.req_operand_a_1 : bus.req_operand_a_0;
                cur_b    = cur_port ? bus.req_operand_b_1 : bus.req_operand_b_0;
                inflight = 1'b1;
            end else if (inflight && busy && bus.rsp_valid == 2'b00) begin
                check("alu_op_a", {28'd0, alu_operation, alu_operand_a}, {28'd0, cur_op, cur_a});
                check("alu_b", 64'(alu_operand_b), 64'(cur_b));
            end

            if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00) begin
                check("rsp_valid_port", 64'(bus.rsp_valid), cur_port ? 64'd2 : 64'd1);
                check("latency", 64'(cyc - cur_edge), 64'(cycles(cur_op)));
                inflight = 1'b0;
            end

            if (prev_hold) begin
                check("rsp_hold_valid", 64'(bus.rsp_valid), 64'(prev_rv));
                check("rsp_hold_data", {30'd0, bus.rsp_error_flag, bus.rsp_result}, {30'd0, prev_err, prev_res});
            end

            if (bus.rsp_valid != 2'b00) begin
                p = bus.rsp_valid[1];
                if (bus.rsp_ready[p]) begin
                    if ((p ? exp_q1.size() : exp_q0.size()) == 0) begin
                        check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                    end else begin
                        e = p ? exp_q1.pop_front() : exp_q0.pop_front();
                        check(p ? "rsp_p1" : "rsp_p0", {30'd0, bus.rsp_error_flag, bus.rsp_result}, {30'd0, e.err, e.res});
                        if (e.err != 2'b00) model_errors++;
                    end
                    prev_hs   = 1'b1;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                end
            end else begin
                prev_hold = 1'b0;
            end
            prev_rv  = bus.rsp_valid;
            prev_res = bus.rsp_result;
            prev_err = bus.rsp_error_flag;
        end
    end

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [8];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd6, 4'd11};
        return ops[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] rand_b();
        if ($urandom_range(0, 3) == 0) return 32'd0;
        return 32'($urandom_range(1, 1000));
    endfunction

    initial begin : main
        bit seen;
        for (int i = 0; i < 2; i++) begin
            drv_valid[i] = 1'b0; drv_op[i] = 4'd0; drv_a[i] = 32'd0; drv_b[i] = 32'd0;
            model_grants[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready_valid", {60'd0, bus.req_ready, bus.rsp_valid}, 64'd0);
        check("reset_rsp", {30'd0, bus.rsp_error_flag, bus.rsp_result}, 64'd0);
        check("reset_alu", {28'd0, alu_operation, alu_operand_a}, 64'd0);
        check("reset_alu_b", 64'(alu_operand_b), 64'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #2;

        drive(0, 4'd0, 32'd10, 32'd5);
        wait_idle();
        drive(1, 4'd6, 32'd40, 32'd4);
        wait_idle();
        drive(0, 4'd6, 32'd10, 32'd0);
        wait_idle();
`ifdef ALU_ARB_STATS_EN
        check("stat_errors_div0", 64'(stat_errors), 64'd1);
        check("stat_grants", {32'd0, stat_grants_1, stat_grants_0}, {32'd0, 16'd1, 16'd2});
`endif

        fork
            begin repeat (4) drive(0, 4'd1, 32'd20, 32'd8); end
            begin repeat (4) drive(1, 4'd2, 32'd15, 32'd5); end
        join
        wait_idle();

        rr_mode = 2;
        drive(1, 4'd0, 32'd3, 32'd4);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (bus.rsp_valid[1]) seen = 1'b1;
        end
        check("hold_rsp_seen", 64'(seen), 64'd1);
        fork
            drive(0, 4'd5, 32'hF0F0_1234, 32'h0FF0_4321);
            begin repeat (5) @(negedge clock); rr_mode = 0; end
        join
        wait_idle();

        rr_mode = 1;
        fork
            begin repeat (20) drive(0, rand_op(), $urandom, rand_b()); end
            begin
                repeat (20) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clock); #2; end
                    drive(1, rand_op(), $urandom, rand_b());
                end
            end
        join
        wait_idle();
        rr_mode = 0;
        @(posedge clock);
        #2;

        drive(1, 4'd6, 32'd100, 32'd7);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_ready_valid", {60'd0, bus.req_ready, bus.rsp_valid}, 64'd0);
        check("midreset_alu", {28'd0, alu_operation, alu_operand_a}, 64'd0);
        check("midreset_rsp", {30'd0, bus.rsp_error_flag, bus.rsp_result}, 64'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        check("aborted_no_rsp", 64'(seen), 64'd0);
        @(posedge clock);
        #2;
        fork
            drive(0, 4'd1, 32'd20, 32'd8);
            drive(1, 4'd2, 32'd15, 32'd5);
        join
        wait_idle();

`ifdef ALU_ARB_STATS_EN
        check("stat_grants_0", 64'(stat_grants_0), 64'(model_grants[0]));
        check("stat_grants_1", 64'(stat_grants_1), 64'(model_grants[1]));
        check("stat_errors", 64'(stat_errors), 64'(model_errors));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
